// File: rtl/ctl_bram_arbiter_if.sv
// ctl_bram_arbiter_if: requester handshake, read-return and BRAM port B
// signals for ctl_bram_arbiter. The arbiter uses the slave modport; the
// requester/BRAM side uses the master modport.
interface ctl_bram_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    // Requester handshake
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      req_we;
    logic [N_REQ-1:0]      req_lock;
    logic [ADDR_WIDTH-1:0] req_addr [N_REQ];
    logic [DATA_WIDTH-1:0] req_din  [N_REQ];

    // Read return
    logic [N_REQ-1:0]      rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    // BRAM port B
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_din, bram_dout,
        output req_ready, rsp_valid, rsp_data, bram_we, bram_addr, bram_din
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_din, bram_dout,
        input  req_ready, rsp_valid, rsp_data, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/ctl_bram_arbiter.sv
// ctl_bram_arbiter: shares controller BRAM port B between N_REQ requesters.
// One transfer per cycle, registered BRAM port, in-order read return with
// fixed latency, and a lock that lets one requester own the port for a burst.
// Build option: define CTL_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with index 0 highest (no pointer register).
module ctl_bram_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    ctl_bram_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        owner_q, owner_d;
`ifdef CTL_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        cand;
`endif

    logic [N_REQ-1:0]      grant;
    logic [IDW-1:0]        win_idx;
    logic                  found;
    logic                  xfer;
    logic                  rd_in;

    logic                  bram_we_q;
    logic [ADDR_WIDTH-1:0] bram_addr_q;
    logic [DATA_WIDTH-1:0] bram_din_q;

    // Delay line: stage j holds the transfer issued j edges ago.
    logic [READ_LATENCY:0] vld_pipe_q;
    logic [IDW-1:0]        id_pipe_q [READ_LATENCY+1];

    logic [N_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    // Winner select: owner only while locked, else policy search; no grant in reset.
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
`ifdef CTL_ARB_ROUND_ROBIN_EN
        cand    = '0;
`endif
        if (rst_n_i) begin
            if (state_q == ST_LOCKED) begin
                // Owner keeps the port even while idle; others must wait.
                found   = bus.req_valid[owner_q];
                win_idx = owner_q;
            end else begin
`ifdef CTL_ARB_ROUND_ROBIN_EN
                // Walk from farthest to nearest so the first valid at/after ptr wins.
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    cand = IDW'((int'(ptr_q) + k) % N_REQ);
                    if (bus.req_valid[cand]) begin
                        found   = 1'b1;
                        win_idx = cand;
                    end
                end
`else
                // Descending walk leaves the lowest valid index as winner.
                for (int k = N_REQ - 1; k >= 0; k--) begin
                    if (bus.req_valid[k]) begin
                        found   = 1'b1;
                        win_idx = IDW'(k);
                    end
                end
`endif
            end
            if (found) grant[win_idx] = 1'b1;
        end
    end

    assign xfer  = found;
    assign rd_in = xfer & ~bus.req_we[win_idx];

    // Lock state / owner next-state; only a transfer can change them.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (xfer) begin
            if (bus.req_lock[win_idx]) begin
                state_d = ST_LOCKED;
                owner_d = win_idx;
            end else begin
                state_d = ST_OPEN;
            end
        end
    end

`ifdef CTL_ARB_ROUND_ROBIN_EN
    // Pointer moves to last winner + 1 (mod N_REQ) on each transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end
`endif

    // Lock state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_OPEN;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Registered BRAM port: WE pulses per write, address/data hold when idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_we_q <= xfer & bus.req_we[win_idx];
            if (xfer) begin
                bram_addr_q <= bus.req_addr[win_idx];
                bram_din_q  <= bus.req_din[win_idx];
            end
        end
    end

    // Return delay line; writes travel as bubbles so ordering is preserved.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe_q <= '0;
            for (int j = 0; j <= READ_LATENCY; j++) id_pipe_q[j] <= '0;
        end else begin
            vld_pipe_q   <= {vld_pipe_q[READ_LATENCY-1:0], rd_in};
            id_pipe_q[0] <= win_idx;
            for (int j = 1; j <= READ_LATENCY; j++) id_pipe_q[j] <= id_pipe_q[j-1];
        end
    end

    // Capture BRAM data at the line output and strobe the issuing requester.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (vld_pipe_q[READ_LATENCY]) begin
                rsp_valid_q[id_pipe_q[READ_LATENCY]] <= 1'b1;
                rsp_data_q                           <= bus.bram_dout;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_ctl_bram_arbiter.sv
// tb_ctl_bram_arbiter: directed bench for ctl_bram_arbiter with a BRAM model
// (READ_LATENCY=2, read-first) and a scoreboard of expected read returns.
module tb_ctl_bram_arbiter;
    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 16;
    localparam int RL = 2;

    typedef struct {
        int          id;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nerr;
    int   nchk;
    int   rsp_cnt;
    exp_t sb[$];

    logic [DW-1:0] mem    [512];
    logic [DW-1:0] shadow [512];
    logic [DW-1:0] r1, r2;

    ctl_bram_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ctl_bram_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port B model: two-stage registered read, read-first on write.
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        r1 <= mem[bus.bram_addr];
        r2 <= r1;
    end
    assign bus.bram_dout = r2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid !== '0) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(bus.rsp_valid), 32'(1) << e.id);
                check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i] = v;
        bus.req_we[i]    = we;
        bus.req_lock[i]  = lk;
        bus.req_addr[i]  = a;
        bus.req_din[i]   = d;
    endtask

    // Check READY against the expected grant, record the transfer, advance one cycle.
    task automatic step(input string tag, input logic [N-1:0] exp_rdy);
        #1;
        check(tag, 32'(bus.req_ready), 32'(exp_rdy));
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                if (bus.req_we[i]) shadow[bus.req_addr[i]] = bus.req_din[i];
                else sb.push_back('{id: i, data: shadow[bus.req_addr[i]]});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [N-1:0] e;
        nerr = 0;
        nchk = 0;
        rsp_cnt = 0;
        for (int a = 0; a < 512; a++) begin
            mem[a]    = 16'(16'h1232 + a);
            shadow[a] = 16'(16'h1232 + a);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset state, with every requester asserting VALID.
        rst_n = 1'b0;
        bus.req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'(0));
        check("rst_bram_we", 32'(bus.bram_we), 32'(0));
        check("rst_bram_addr", 32'(bus.bram_addr), 32'(0));
        check("rst_bram_din", 32'(bus.bram_din), 32'(0));
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read with exact latency: strobe appears 3 edges after accept.
        set_req(0, 1'b1, 1'b0, 1'b0, 9'h002, '0);
        step("rd0_grant", 4'b0001);
        check("rd0_bram_addr", 32'(bus.bram_addr), 32'h002);
        check("rd0_bram_we", 32'(bus.bram_we), 32'(0));
        bus.req_valid[0] = 1'b0;
        step("idle", 4'b0000);
        check("rd0_lat1", 32'(bus.rsp_valid), 32'(0));
        step("idle", 4'b0000);
        check("rd0_lat2", 32'(bus.rsp_valid), 32'(0));
        step("idle", 4'b0000);
        check("rd0_lat3_vld", 32'(bus.rsp_valid), 32'b0001);
        check("rd0_lat3_data", 32'(bus.rsp_data), 32'h1234);
        step("idle", 4'b0000);
        check("rd0_one_cycle", 32'(bus.rsp_valid), 32'(0));

        // Write then read of the same address on consecutive cycles.
        c0 = rsp_cnt;
        set_req(1, 1'b1, 1'b1, 1'b0, 9'h00A, 16'hBEEF);
        step("wr1_grant", 4'b0010);
        check("wr1_bram_we", 32'(bus.bram_we), 32'(1));
        check("wr1_bram_addr", 32'(bus.bram_addr), 32'h00A);
        check("wr1_bram_din", 32'(bus.bram_din), 32'hBEEF);
        bus.req_we[1] = 1'b0;
        step("rd1_grant", 4'b0010);
        check("rd1_bram_we", 32'(bus.bram_we), 32'(0));
        bus.req_valid[1] = 1'b0;
        drain("wr_rd_drain");
        check("wr_rd_rsp_count", 32'(rsp_cnt - c0), 32'(1));

        // Single read by req3 so the round-robin pointer lands on 0.
        set_req(3, 1'b1, 1'b0, 1'b0, 9'h003, '0);
        step("rd3_grant", 4'b1000);
        bus.req_valid[3] = 1'b0;
        drain("rd3_drain");

        // Contention: all four hold VALID for 8 cycles.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(9'h020 + i), '0);
        for (int k = 0; k < 8; k++) begin
`ifdef CTL_ARB_ROUND_ROBIN_EN
            e = N'(1 << (k % N));
`else
            e = 4'b0001;
`endif
            step("contend_grant", e);
        end
        bus.req_valid = '0;
        drain("contend_drain");

        // Lock burst: req2 owns the port for 249 reads while req0/req1 wait.
        c0 = rsp_cnt;
        set_req(0, 1'b0, 1'b0, 1'b0, 9'h030, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, 9'h031, '0);
        set_req(2, 1'b1, 1'b0, 1'b1, 9'h100, '0);
        for (int i = 0; i < 249; i++) begin
            bus.req_addr[2] = AW'(256 + i);
            bus.req_lock[2] = (i != 248);
            if (i == 1) begin
                bus.req_valid[0] = 1'b1;
                bus.req_valid[1] = 1'b1;
            end
            step("lock_burst_grant", 4'b0100);
        end
        bus.req_valid[2] = 1'b0;
        step("post_lock_req0", 4'b0001);
        bus.req_valid[0] = 1'b0;
        step("post_lock_req1", 4'b0010);
        bus.req_valid[1] = 1'b0;
        drain("lock_drain");
        check("lock_rsp_count", 32'(rsp_cnt - c0), 32'(251));

        // Owner bubble: locked req3 goes idle for 3 cycles.
        set_req(3, 1'b1, 1'b1, 1'b1, 9'h040, 16'hCAFE);
        step("lock3_wr_grant", 4'b1000);
        bus.req_valid[3] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_valid[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step("bubble_ready", 4'b0000);
            check("bubble_bram_we", 32'(bus.bram_we), 32'(0));
            check("bubble_bram_addr", 32'(bus.bram_addr), 32'h040);
        end
        set_req(3, 1'b1, 1'b0, 1'b0, 9'h040, '0);
        step("unlock3_grant", 4'b1000);
        bus.req_valid[3] = 1'b0;
        step("after_unlock_req0", 4'b0001);
        bus.req_valid[0] = 1'b0;
        step("after_unlock_req1", 4'b0010);
        bus.req_valid[1] = 1'b0;
        drain("bubble_drain");

        // Reset mid-flight: two locked reads in flight, then async reset.
        set_req(2, 1'b1, 1'b0, 1'b1, 9'h050, '0);
        step("mf_rd_a", 4'b0100);
        bus.req_addr[2] = 9'h051;
        step("mf_rd_b", 4'b0100);
        bus.req_valid[2] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        c0 = rsp_cnt;
        check("mf_bram_we", 32'(bus.bram_we), 32'(0));
        check("mf_bram_addr", 32'(bus.bram_addr), 32'(0));
        check("mf_bram_din", 32'(bus.bram_din), 32'(0));
        check("mf_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("mf_rsp_data", 32'(bus.rsp_data), 32'(0));
        set_req(0, 1'b1, 1'b0, 1'b0, 9'h060, '0);
        #1;
        check("mf_ready_in_reset", 32'(bus.req_ready), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("mf_lock_cleared", 4'b0001);
        bus.req_valid[0] = 1'b0;
        drain("mf_drain");
        repeat (4) @(negedge clk);
        check("mf_rsp_count", 32'(rsp_cnt - c0), 32'(1));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
